// File: rtl/gpac_adc_sample_framer.sv
// GPAC ADC sample framer: captures a programmed burst of 14-bit samples after
// START or a TRIGGER rising edge and packs two samples per 32-bit FIFO word.
module gpac_adc_sample_framer #(
  parameter logic [2:0]  HEADER_ID = 3'd0,
  parameter int unsigned CNT_WIDTH = 24,
  parameter int unsigned DLY_WIDTH = 16
) (
  input  logic                 ADC_ENC,
  input  logic                 ADC_RST,
  input  logic [13:0]          ADC_IN,
  input  logic                 START,
  input  logic                 TRIGGER,
  input  logic                 CONF_EN_TRIGGER,
  input  logic [CNT_WIDTH-1:0] CONF_DATA_CNT,
  input  logic [DLY_WIDTH-1:0] CONF_DELAY,
  input  logic                 FIFO_FULL,
  output logic                 FIFO_WRITE,
  output logic [31:0]          FIFO_DATA,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [7:0]           LOST_CNT
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_DELAY   = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DLY_WIDTH-1:0] dly_q, dly_d;
  logic [DLY_WIDTH-1:0] conf_dly_q, conf_dly_d;
  logic                 trig_q, trig_d;
  logic [13:0]          half_q, half_d;
  logic                 half_vld_q, half_vld_d;
  logic                 sof_q, sof_d;
  logic                 wr_q, wr_d;
  logic [31:0]          data_q, data_d;
  logic                 done_q, done_d;
  logic [7:0]           lost_q, lost_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dly_d      = dly_q;
    conf_dly_d = conf_dly_q;
    trig_d     = TRIGGER;
    half_d     = half_q;
    half_vld_d = half_vld_q;
    sof_d      = sof_q;
    wr_d       = 1'b0;
    data_d     = data_q;
    done_d     = done_q;
    lost_d     = lost_q;

    // A word is dropped when its write slot coincides with FIFO_FULL
    if (wr_q && FIFO_FULL && (lost_q != 8'hFF))
      lost_d = lost_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          conf_dly_d = CONF_DELAY;
          cnt_d      = CONF_DATA_CNT;
          done_d     = 1'b0;
          lost_d     = '0;
          half_vld_d = 1'b0;
          sof_d      = 1'b1;
          if (CONF_DATA_CNT == '0) begin
            done_d = 1'b1;
          end else if (CONF_EN_TRIGGER) begin
            state_d = S_ARMED;
          end else if (CONF_DELAY != '0) begin
            state_d = S_DELAY;
            dly_d   = CONF_DELAY;
          end else begin
            state_d = S_CAPTURE;
          end
        end
      end
      S_ARMED: begin
        if (TRIGGER && !trig_q) begin
          if (conf_dly_q != '0) begin
            state_d = S_DELAY;
            dly_d   = conf_dly_q;
          end else begin
            state_d = S_CAPTURE;
          end
        end
      end
      S_DELAY: begin
        if (dly_q == DLY_WIDTH'(1))
          state_d = S_CAPTURE;
        else
          dly_d = dly_q - DLY_WIDTH'(1);
      end
      default: begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (half_vld_q) begin
          wr_d       = 1'b1;
          data_d     = {HEADER_ID, sof_q, half_q, ADC_IN};
          sof_d      = 1'b0;
          half_vld_d = 1'b0;
        end else if (cnt_q == CNT_WIDTH'(1)) begin
          wr_d   = 1'b1;
          data_d = {HEADER_ID, sof_q, ADC_IN, 14'h0000};
          sof_d  = 1'b0;
        end else begin
          half_d     = ADC_IN;
          half_vld_d = 1'b1;
        end
        if (cnt_q == CNT_WIDTH'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge ADC_ENC) begin
    if (ADC_RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dly_q      <= '0;
      conf_dly_q <= '0;
      trig_q     <= 1'b0;
      half_q     <= '0;
      half_vld_q <= 1'b0;
      sof_q      <= 1'b0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      lost_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dly_q      <= dly_d;
      conf_dly_q <= conf_dly_d;
      trig_q     <= trig_d;
      half_q     <= half_d;
      half_vld_q <= half_vld_d;
      sof_q      <= sof_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      lost_q     <= lost_d;
    end
  end

  // Strobe is gated by FIFO_FULL in the write cycle itself; data stays registered
  assign FIFO_WRITE = wr_q & ~FIFO_FULL;
  assign FIFO_DATA  = data_q;
  assign BUSY       = (state_q != S_IDLE);
  assign DONE       = done_q;
  assign LOST_CNT   = lost_q;

endmodule

// File: doc/gpac_adc_sample_framer.md
Name: gpac_adc_sample_framer

Overview:
- Sits directly downstream of the GPAC ADC input-buffer/deserialiser stage, in the ADC_ENC domain; one instance per ADC channel.
- Takes the 14-bit parallel sample produced every ADC_ENC cycle and captures a programmed number of samples after a software start or an external trigger, with optional delay.
- Packs two samples per 32-bit word and writes them to the downstream FIFO. Counts words dropped because the FIFO was full.

Parameters:
- HEADER_ID, 0, 3-bit channel/source identifier placed in bits [31:29] of every word.
- CNT_WIDTH, 24, width of the sample counter and CONF_DATA_CNT.
- DLY_WIDTH, 16, width of the delay counter and CONF_DELAY.

Ports:
- ADC_ENC  in  1  sample clock; all logic on posedge.
- ADC_RST  in  1  synchronous, active-high reset.
- ADC_IN  in  14  parallel sample from the deserialiser, new value every cycle.
- START  in  1  single-cycle capture request.
- TRIGGER  in  1  external trigger level; rising edge is used.
- CONF_EN_TRIGGER  in  1  1 = wait for TRIGGER after START; 0 = start immediately.
- CONF_DATA_CNT  in  CNT_WIDTH  number of samples to capture.
- CONF_DELAY  in  DLY_WIDTH  cycles to skip between start/trigger and the first sample.
- FIFO_FULL  in  1  downstream FIFO full.
- FIFO_WRITE  out  1  write strobe, one cycle per word.
- FIFO_DATA  out  32  packed word.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  capture complete; level signal.
- LOST_CNT  out  8  saturating count of dropped words.

Behaviour:
- Reset values:
  - State IDLE.
  - FIFO_WRITE=0, FIFO_DATA=0, BUSY=0, DONE=0, LOST_CNT=0.
  - Partial word, counters and trigger edge register cleared.
  - Reset mid-capture discards everything and emits no further writes.
- Configuration latch: CONF_* are latched on the cycle START is accepted. Later changes have no effect on the running capture.
- States: IDLE -> ARMED -> DELAY -> CAPTURE -> IDLE.
- IDLE:
  - START=1: latch config, DONE<=0, LOST_CNT<=0.
  - If latched CONF_DATA_CNT==0: stay IDLE, DONE<=1 next cycle, no writes.
  - Otherwise go to ARMED if CONF_EN_TRIGGER=1; else to DELAY if CONF_DELAY!=0; else to CAPTURE.
- START while BUSY is ignored.
- ARMED:
  - Rising edge = TRIGGER=1 and registered previous TRIGGER=0. The edge register runs in every state, so a TRIGGER already high at START does not fire.
  - On an edge, go to DELAY if CONF_DELAY!=0, else to CAPTURE.
- DELAY: counts CONF_DELAY cycles, then CAPTURE.
- CAPTURE timing: the first captured sample is ADC_IN at the first cycle in CAPTURE. With no trigger and no delay, that is the ADC_IN present one cycle after START. Exactly CONF_DATA_CNT consecutive samples are taken, one per cycle, no gaps.
- Packing: FIFO_DATA = {HEADER_ID[2:0], SOF, S_a[13:0], S_b[13:0]}.
  - S_a is the earlier sample and S_b the later.
  - SOF=1 only on the first word of a capture.
  - Odd CONF_DATA_CNT: the last word has S_b=14'h0000.
- Write timing: FIFO_WRITE pulses in the cycle after S_b is captured, or after the last sample for odd counts. FIFO_DATA is registered and valid with FIFO_WRITE.
- Full FIFO: if FIFO_FULL=1 in the cycle the word would be written, FIFO_WRITE stays 0 and LOST_CNT increments, saturating at 255. Capture never stalls.
- Completion: after the final sample, the state returns to IDLE. The last FIFO_WRITE and DONE<=1 occur in the same cycle. BUSY falls in that same cycle. DONE stays high until the next accepted START.
- Counter widths: the sample counter is CNT_WIDTH bits, so the maximum capture is 2^CNT_WIDTH-1 samples. No wrap inside a capture.

Test Plan:
- Immediate mode: CONF_EN_TRIGGER=0, CONF_DELAY=0, CONF_DATA_CNT=4, ADC_IN ramp 0,1,2… with START at the cycle where ADC_IN=10 -> exactly two writes: {HEADER_ID,1,11,12} then {HEADER_ID,0,13,14}. DONE rises with the 2nd write, BUSY low afterwards.
- Odd count plus delay: CONF_DATA_CNT=3, CONF_DELAY=5, same ramp, START at ADC_IN=10 -> writes {…,1,16,17} and {…,0,18,0}. No write before 7 cycles after START.
- Trigger mode: CONF_EN_TRIGGER=1, TRIGGER already high at START, later low and then high again -> no capture on the initial level. Capture starts on the later rising edge. BUSY high throughout ARMED.
- Backpressure: CONF_DATA_CNT=8, FIFO_FULL held high for the 2nd and 3rd write slots -> only words 1 and 4 are written, LOST_CNT=2, DONE=1, sample alignment in word 4 unchanged.
- Reset and restart: assert ADC_RST mid-CAPTURE for 1 cycle -> no further FIFO_WRITE, all outputs 0. A new START then captures normally with SOF=1.
- Edge cases: CONF_DATA_CNT=0 -> DONE=1 one cycle after START with no writes. START during BUSY -> ignored, word count unchanged.
